// File: rtl/dmem_arbiter.sv
// Data RAM arbiter: shares the single-port data RAM between the MEM-stage
// CPU port and an external burst loader/debug port.  The CPU has priority,
// but once a burst is granted it is guaranteed at least one RAM cycle in two.
// An EXT request that keeps losing to the CPU is force-granted after MAXWAIT
// refused cycles.
module dmem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int LENW    = 8,
    parameter int MAXWAIT = 8
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            cpu_req,
    input  logic            cpu_we,
    input  logic [AW-1:0]   cpu_addr,
    input  logic [DW-1:0]   cpu_wdata,
    output logic [DW-1:0]   cpu_rdata,
    output logic            cpu_stall,
    input  logic            ext_req,
    input  logic            ext_we,
    input  logic [AW-1:0]   ext_addr,
    input  logic [LENW-1:0] ext_len,
    input  logic [DW-1:0]   ext_wdata,
    output logic            ext_gnt,
    output logic            ext_beat,
    output logic [DW-1:0]   ext_rdata,
    output logic            ext_done,
    output logic            ram_we,
    output logic [AW-1:0]   ram_addr,
    output logic [DW-1:0]   ram_wdata,
    input  logic [DW-1:0]   ram_rdata
);

    localparam int WCW = (MAXWAIT < 1) ? 1 : $clog2(MAXWAIT + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAXWAIT);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            we_q, we_d;
    logic [LENW-1:0] beats_q, beats_d;
    logic [WCW-1:0]  wait_q, wait_d;
    logic            last_cpu_q, last_cpu_d;

    logic            grant;

    // Read data is shared by both ports; each port qualifies it itself.
    assign cpu_rdata = ram_rdata;
    assign ext_rdata = ram_rdata;

    assign grant = ext_req && (!cpu_req || (wait_q == WAIT_MAX));

    // Next-state, RAM routing and handshake decode.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        beats_d    = beats_q;
        wait_d     = wait_q;
        last_cpu_d = last_cpu_q;

        cpu_stall  = 1'b0;
        ext_gnt    = 1'b0;
        ext_beat   = 1'b0;
        ext_done   = 1'b0;
        ram_addr   = cpu_addr;
        ram_wdata  = cpu_wdata;
        ram_we     = cpu_req && cpu_we;

        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    ext_gnt    = 1'b1;
                    addr_d     = ext_addr;
                    we_d       = ext_we;
                    beats_d    = (ext_len == '0) ? LENW'(1) : ext_len;
                    last_cpu_d = cpu_req;
                    wait_d     = '0;
                    state_d    = BURST;
                end else begin
                    last_cpu_d = 1'b0;
                    if (ext_req) begin
                        if (wait_q != WAIT_MAX) begin
                            wait_d = wait_q + WCW'(1);
                        end
                    end else begin
                        wait_d = '0;
                    end
                end
            end

            BURST: begin
                if (cpu_req && !last_cpu_q) begin
                    // CPU keeps the RAM (default routing); next cycle is EXT's.
                    last_cpu_d = 1'b1;
                end else begin
                    ram_addr   = addr_q;
                    ram_we     = we_q;
                    ram_wdata  = ext_wdata;
                    ext_beat   = 1'b1;
                    cpu_stall  = cpu_req;
                    addr_d     = addr_q + AW'(4);
                    beats_d    = beats_q - LENW'(1);
                    last_cpu_d = 1'b0;
                    if (beats_q <= LENW'(1)) begin
                        ext_done = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // Reset must block RAM writes and handshakes in the very cycle it rises.
        if (resetn) begin
            ram_we    = 1'b0;
            cpu_stall = 1'b0;
            ext_gnt   = 1'b0;
            ext_beat  = 1'b0;
            ext_done  = 1'b0;
        end
    end

    // State and burst-context registers.
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            beats_q    <= '0;
            wait_q     <= '0;
            last_cpu_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            beats_q    <= beats_d;
            wait_q     <= wait_d;
            last_cpu_q <= last_cpu_d;
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM between the pipeline MEM stage (CPU port) and an external burst loader/debug port (EXT port).
- Sits between the EX/MEM register outputs (store enable, ALU address, store data) and the data RAM; its read data feeds the MEM/WB register.
- Drives a pipeline-wide stall whenever the CPU access is deferred.
- Guarantees the EXT port a bounded wait. Under contention, the EXT port gets at least one RAM cycle in two.

Parameters:
AW, 32, address width (byte address)
DW, 32, data width
LENW, 8, burst length field width
MAXWAIT, 8, cycles EXT may be refused while CPU is busy before a forced grant (≥1)

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous reset, active-high (1 = reset asserted)
cpu_req  in  1  MEM stage performs a load or store this cycle
cpu_we  in  1  1 = store
cpu_addr  in  AW  byte address (ALU result)
cpu_wdata  in  DW  store data
cpu_rdata  out  DW  load data (valid in cycles where cpu_req=1 and cpu_stall=0)
cpu_stall  out  1  CPU access not performed this cycle; pipeline must hold
ext_req  in  1  burst request, held high until ext_gnt
ext_we  in  1  1 = write burst
ext_addr  in  AW  burst start byte address
ext_len  in  LENW  number of beats; 0 means 1
ext_wdata  in  DW  write data, must be valid in each ext_beat cycle
ext_gnt  out  1  one-cycle pulse: burst accepted and parameters latched
ext_beat  out  1  one EXT beat performed this cycle
ext_rdata  out  DW  read data, valid when ext_beat=1 and ext_we latched 0
ext_done  out  1  pulse coincident with the final beat
ram_we  out  1  RAM write enable
ram_addr  out  AW  RAM address
ram_wdata  out  DW  RAM write data
ram_rdata  in  DW  RAM read data (combinational read, write on clock edge)

Behaviour:
- FSM states: IDLE and BURST.
- Registers:
  - state
  - addr_r, we_r, beats_r (remaining beats)
  - wait_cnt (saturates at MAXWAIT)
  - last_cpu (CPU was served in the previous cycle while a grant or burst was active)
- While resetn=1:
  - state=IDLE; all registers 0.
  - ram_we, cpu_stall, ext_gnt, ext_beat and ext_done are forced to 0 combinationally.
  - A reset mid-burst suppresses any further RAM write immediately and abandons the burst. No ext_done is issued.
- IDLE:
  - The RAM is routed to the CPU port. cpu_stall=0.
  - Grant condition: ext_req && (!cpu_req || wait_cnt==MAXWAIT).
  - On grant:
    - ext_gnt=1.
    - Latch addr_r=ext_addr, we_r=ext_we, beats_r=max(ext_len,1).
    - last_cpu=cpu_req; wait_cnt=0.
    - Next state is BURST.
  - The grant cycle performs no EXT beat. A CPU access in the grant cycle still completes.
  - When ext_req=1 and there is no grant, wait_cnt increments. When ext_req=0, wait_cnt is cleared.
- BURST:
  - If cpu_req && !last_cpu: the CPU is served (cpu_stall=0, RAM routed to CPU), there is no beat, and last_cpu is set to 1.
  - Otherwise an EXT beat occurs:
    - ram_addr=addr_r, ram_we=we_r, ram_wdata=ext_wdata, ext_beat=1.
    - cpu_stall=cpu_req.
    - addr_r+=4 (wraps modulo 2^AW); beats_r-=1; last_cpu=0.
  - When beats_r==1 on a beat: ext_done=1 and next state is IDLE.
  - ext_req is ignored during BURST. A request still high after ext_done is re-evaluated in IDLE the next cycle with wait_cnt=0.
- Bounds:
  - Worst-case CPU stall is 1 cycle per 2.
  - Worst-case EXT wait before grant is MAXWAIT+1 cycles.
  - Burst duration is len cycles uncontended and ≤2·len cycles under continuous cpu_req.
- Pass-through outputs:
  - cpu_rdata=ram_rdata and ext_rdata=ram_rdata, both unconditionally.
  - When no port is selected: ram_addr=cpu_addr, ram_wdata=cpu_wdata, ram_we=0.

Test Plan:
1. Reset. CPU store 0xDEADBEEF to 0x10, then load 0x10 → ram_we=1 in the store cycle, cpu_rdata=0xDEADBEEF, cpu_stall stays 0, EXT outputs stay 0.
2. CPU idle. EXT write burst, addr 0x100, len 4, data 1..4 → ext_gnt at cycle N; beats N+1..N+4 at 0x100/0x104/0x108/0x10C; ext_done at N+4; RAM holds 1..4.
3. cpu_req held high. ext_req rises at T, len 3 → ext_gnt at T+8 (MAXWAIT). Then beat/CPU alternate starting with a beat at T+9; cpu_stall=1 exactly on the beat cycles T+9, T+11, T+13; ext_done at T+13.
4. ext_len=0 read burst at 0x100 → exactly one beat, ext_rdata=1, ext_done in the same cycle as the beat.
5. Assert resetn after beat 2 of a 4-beat write → ram_we drops in the same cycle; 0x108 and 0x10C are unchanged; no ext_done. After release, a re-request restarts at ext_addr.
6. EXT read burst len 4 from 0x100 with CPU loads interleaved → ext_rdata sequence 1,2,3,4 on ext_beat cycles; CPU loads return correct data with at most one stall between grants.
